// File: rtl/xcorr_peak.sv
// Scans the xcorr result RAM for its maximum and reports value, address and signed lag.
// Optional XCORR_PEAK_THRESH_EN adds a threshold input and a registered found flag.
module xcorr_peak #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int N      = 256,
    parameter int CENTER = 128,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_q,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] peak_val,
    output logic [ADDR_W-1:0] peak_idx,
    output logic [ADDR_W:0]   lag
`ifdef XCORR_PEAK_THRESH_EN
    ,
    input  logic [DATA_W-1:0] thresh,
    output logic              found
`endif
);

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   CTR_EXT = (ADDR_W + 1)'(CENTER);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    state_t state, next_state;

    logic              issue_vld;
    logic              cap_vld;
    logic [ADDR_W-1:0] cap_idx;
    logic [DATA_W-1:0] run_max;
    logic [ADDR_W-1:0] run_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // With a one-edge RAM the last sample is already captured when N-1 retires,
    // so the drain phase is skipped entirely.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SCAN;
            SCAN:    if (s_addr == LAST) next_state = (RD_LAT == 1) ? DONE : DRAIN;
            DRAIN:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        issue_vld = (state == SCAN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_addr <= '0;
        end else if (state == SCAN && s_addr != LAST) begin
            s_addr <= s_addr + 1'b1;
        end else if (state == DONE) begin
            s_addr <= '0;
        end
    end

    // Delay the issued address by the RAM latency so each sample meets its own index.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign cap_vld = issue_vld;
            assign cap_idx = s_addr;
        end else begin : g_lat2
            logic              vld_d;
            logic [ADDR_W-1:0] idx_d;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_d <= 1'b0;
                    idx_d <= '0;
                end else begin
                    vld_d <= issue_vld;
                    idx_d <= s_addr;
                end
            end
            assign cap_vld = vld_d;
            assign cap_idx = idx_d;
        end
    endgenerate

    // Strict compare keeps the lowest address on ties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_max <= '0;
            run_idx <= '0;
        end else if (state == IDLE && start) begin
            run_max <= '0;
            run_idx <= '0;
        end else if (cap_vld && s_q > run_max) begin
            run_max <= s_q;
            run_idx <= cap_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            peak_val <= '0;
            peak_idx <= '0;
            lag      <= '0;
        end else if (state == DONE) begin
            done     <= 1'b1;
            peak_val <= run_max;
            peak_idx <= run_idx;
            lag      <= {1'b0, run_idx} - CTR_EXT;
        end else begin
            done     <= 1'b0;
        end
    end

`ifdef XCORR_PEAK_THRESH_EN
    logic [DATA_W-1:0] thresh_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thresh_q <= '0;
            found    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                thresh_q <= thresh;
            end
            if (state == DONE) begin
                found <= (run_max >= thresh_q);
            end
        end
    end
`endif

endmodule
